// File: rtl/gdt_descriptor_fetch_pkg.sv
// Shared types for the GDT descriptor fetch block: FSM states, fault
// codes, the selector-check result record and the descriptor size.
package gdt_descriptor_fetch_pkg;

   localparam int DESCRIPTOR_BYTES = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOW_REQUEST,
      LOW_WAIT,
      HIGH_REQUEST,
      HIGH_WAIT,
      DONE,
      FAULT
   } state_t;

   typedef enum logic [1:0] {
      FAULT_LDT         = 2'b00,
      FAULT_NULL        = 2'b01,
      FAULT_LIMIT       = 2'b10,
      FAULT_NOT_PRESENT = 2'b11
   } fault_t;

   typedef struct packed {
      logic   fail;
      fault_t kind;
   } check_t;

   // Error code reported with every fault: selector with RPL cleared.
   function automatic logic [15:0] error_code(input logic [15:0] selector);
      return {selector[15:2], 2'b00};
   endfunction

endpackage

// File: rtl/gdt_descriptor_fetch_selector_check.sv
// Combinational selector screening: LDT, null and GDT limit checks in
// priority order.
module selector_check
   import gdt_descriptor_fetch_pkg::*;
(
   input  logic [15:0] selector,
   input  logic [15:0] limit,
   output check_t      result
);

   // Last byte of the 8-byte entry; 17 bits so the compare never wraps.
   logic [16:0] last_byte;
   assign last_byte = {1'b0, selector[15:3], 3'b111};

   // First failing check wins; TI outranks null outranks limit.
   always_comb begin
      result = '{fail: 1'b0, kind: FAULT_LDT};
      if (selector[2])
         result = '{fail: 1'b1, kind: FAULT_LDT};
      else if (selector[15:3] == 13'd0)
         result = '{fail: 1'b1, kind: FAULT_NULL};
      else if (last_byte > {1'b0, limit})
         result = '{fail: 1'b1, kind: FAULT_LIMIT};
   end

endmodule

// File: rtl/gdt_descriptor_fetch.sv
// GDT descriptor fetch: screens a selector against GDTR, then reads the
// 8-byte descriptor as two dword reads (low, then high).
// Optional macro GDT_PRESENT_CHECK_EN: fault (type 11) when the fetched
// descriptor has P = 0 instead of delivering it.
module gdt_descriptor_fetch
   import gdt_descriptor_fetch_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        request_valid,
   output logic        request_ready,
   input  logic [15:0] request_selector,
   input  logic [31:0] GDTR_base,
   input  logic [15:0] GDTR_limit,
   output logic        memory_request_valid,
   input  logic        memory_request_ready,
   output logic [31:0] memory_address,
   input  logic        memory_response_valid,
   input  logic [31:0] memory_response_data,
   output logic        descriptor_valid,
   output logic [63:0] descriptor,
   output logic        fault_valid,
   output logic [1:0]  fault_type,
   output logic [15:0] fault_error_code
);

   state_t      state, state_next;
   logic [15:0] sel_q, limit_q, check_sel, check_limit;
   logic [31:0] base_q, low_q, low_addr;
   fault_t      fault_q;
   check_t      check_res;
   logic        present_fail;

   // The checker sees live inputs while idle (acceptance cycle) and the
   // latched request otherwise, so it always describes the active selector.
   assign check_sel   = (state == IDLE) ? request_selector : sel_q;
   assign check_limit = (state == IDLE) ? GDTR_limit       : limit_q;

   selector_check u_check (
      .selector (check_sel),
      .limit    (check_limit),
      .result   (check_res)
   );

`ifdef GDT_PRESENT_CHECK_EN
   assign present_fail = ~memory_response_data[15];
`else
   assign present_fail = 1'b0;
`endif

   // Entry address wraps modulo 2^32; high dword follows the low one.
   assign low_addr       = base_q + {16'd0, sel_q[15:3], 3'b000};
   assign memory_address = (state == HIGH_REQUEST || state == HIGH_WAIT)
                         ? low_addr + 32'(DESCRIPTOR_BYTES / 2) : low_addr;
   assign fault_type     = fault_q;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and handshake/pulse outputs.
   always_comb begin
      state_next           = state;
      request_ready        = 1'b0;
      memory_request_valid = 1'b0;
      descriptor_valid     = 1'b0;
      fault_valid          = 1'b0;
      case (state)
         IDLE: begin
            request_ready = 1'b1;
            if (request_valid) state_next = check_res.fail ? FAULT : LOW_REQUEST;
         end
         LOW_REQUEST: begin
            memory_request_valid = 1'b1;
            if (memory_request_ready) state_next = LOW_WAIT;
         end
         LOW_WAIT:
            if (memory_response_valid) state_next = HIGH_REQUEST;
         HIGH_REQUEST: begin
            memory_request_valid = 1'b1;
            if (memory_request_ready) state_next = HIGH_WAIT;
         end
         HIGH_WAIT:
            if (memory_response_valid) state_next = present_fail ? FAULT : DONE;
         DONE: begin
            descriptor_valid = 1'b1;
            state_next       = IDLE;
         end
         FAULT: begin
            fault_valid = 1'b1;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latches, dword capture and fault/descriptor result registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sel_q            <= '0;
         base_q           <= '0;
         limit_q          <= '0;
         low_q            <= '0;
         descriptor       <= '0;
         fault_q          <= FAULT_LDT;
         fault_error_code <= '0;
      end else begin
         if (state == IDLE && request_valid) begin
            sel_q   <= request_selector;
            base_q  <= GDTR_base;
            limit_q <= GDTR_limit;
            if (check_res.fail) begin
               fault_q          <= check_res.kind;
               fault_error_code <= error_code(request_selector);
            end
         end
         if (state == LOW_WAIT && memory_response_valid)
            low_q <= memory_response_data;
         if (state == HIGH_WAIT && memory_response_valid) begin
            if (present_fail) begin
               fault_q          <= FAULT_NOT_PRESENT;
               fault_error_code <= error_code(sel_q);
            end else begin
               descriptor <= {memory_response_data, low_q};
            end
         end
      end
   end

endmodule

// File: tb/tb_gdt_descriptor_fetch.sv
// Self-checking bench for gdt_descriptor_fetch: reset values, a table of
// directed vectors, ready-stall and mid-fetch reset sequences, then
// randomized requests against a behavioural model of the selector rules.
module tb_gdt_descriptor_fetch;

   logic        clock = 1'b0, reset = 1'b0;
   logic        request_valid = 1'b0, request_ready;
   logic [15:0] request_selector = '0;
   logic [31:0] GDTR_base = '0;
   logic [15:0] GDTR_limit = '0;
   logic        memory_request_valid, memory_request_ready = 1'b0;
   logic [31:0] memory_address;
   logic        memory_response_valid = 1'b0;
   logic [31:0] memory_response_data = '0;
   logic        descriptor_valid, fault_valid;
   logic [63:0] descriptor;
   logic [1:0]  fault_type;
   logic [15:0] fault_error_code;

   gdt_descriptor_fetch dut (
      .clock(clock), .reset(reset),
      .request_valid(request_valid), .request_ready(request_ready),
      .request_selector(request_selector), .GDTR_base(GDTR_base), .GDTR_limit(GDTR_limit),
      .memory_request_valid(memory_request_valid), .memory_request_ready(memory_request_ready),
      .memory_address(memory_address), .memory_response_valid(memory_response_valid),
      .memory_response_data(memory_response_data), .descriptor_valid(descriptor_valid),
      .descriptor(descriptor), .fault_valid(fault_valid), .fault_type(fault_type),
      .fault_error_code(fault_error_code)
   );

   always #5 clock = ~clock;

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic [31:0] mem [logic [31:0]];
   logic [31:0] addr_q [$];
   bit          rand_mode = 0, stray_en = 0, out_busy = 0, prev_wait = 0;
   int          ready_stall = 0, fixed_delay = -1, out_delay = 0;
   logic [31:0] out_data, prev_addr;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h1357_9BDF;
   endfunction

   // Drives handshakes at the falling edge; the response follows the
   // address handshake after out_delay extra cycles.
   always @(negedge clock) begin
      if (prev_wait) begin
         chk("addr_hold_valid", 64'(memory_request_valid), 64'd1);
         chk("addr_hold_addr", 64'(memory_address), 64'(prev_addr));
      end
      memory_response_valid = 1'b0;
      memory_response_data  = $urandom;
      if (out_busy) begin
         if (out_delay == 0) begin
            memory_response_valid = 1'b1;
            memory_response_data  = out_data;
            out_busy = 0;
         end else out_delay--;
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
         memory_response_valid = 1'b1;
      end
      if (memory_request_valid && ready_stall > 0) begin
         memory_request_ready = 1'b0;
         ready_stall--;
      end else if (rand_mode) memory_request_ready = ($urandom_range(0, 2) != 0);
      else memory_request_ready = 1'b1;
      if (memory_request_valid && memory_request_ready) begin
         addr_q.push_back(memory_address);
         out_busy  = 1;
         out_data  = mem_rd(memory_address);
         out_delay = (fixed_delay >= 0) ? fixed_delay : (rand_mode ? int'($urandom_range(0, 2)) : 0);
      end
      prev_wait = memory_request_valid && !memory_request_ready;
      prev_addr = memory_address;
   end

   // ---------------- transaction driver ----------------
   bit          r_desc, r_fault, r_post_pulse, r_post_ready;
   logic [1:0]  r_ft;
   logic [15:0] r_ec;
   logic [63:0] r_d, r_post_desc, last_desc = '0;
   int          r_lat;

   task automatic run_req(input logic [15:0] sel, input logic [31:0] base, input logic [15:0] lim);
      int  w;
      bit  done;
      r_desc = 0; r_fault = 0; r_lat = 0; r_ft = 'x; r_ec = 'x; r_d = 'x;
      addr_q.delete();
      @(negedge clock);
      request_valid = 1; request_selector = sel; GDTR_base = base; GDTR_limit = lim;
      w = 0;
      while (!request_ready && w < 50) begin @(negedge clock); w++; end
      if (!request_ready) begin request_valid = 0; return; end
      @(negedge clock);
      request_valid = 0;
      request_selector = $urandom; GDTR_base = $urandom; GDTR_limit = $urandom;
      r_lat = 1; done = 0;
      while (!done && r_lat < 200) begin
         if (descriptor_valid) begin r_desc = 1; r_d = descriptor; done = 1; end
         if (fault_valid) begin r_fault = 1; r_ft = fault_type; r_ec = fault_error_code; done = 1; end
         if (!done) begin @(negedge clock); r_lat++; end
      end
      @(negedge clock);
      r_post_pulse = descriptor_valid | fault_valid;
      r_post_ready = request_ready;
      r_post_desc  = descriptor;
   endtask

   task automatic compare(input string tag, input bit ef, input logic [1:0] eft,
                          input logic [15:0] eec, input logic [63:0] ed,
                          input logic [31:0] ea0, input logic [31:0] ea1, input int elat);
      logic [31:0] g0, g1;
      g0 = (addr_q.size() > 0) ? addr_q[0] : 'x;
      g1 = (addr_q.size() > 1) ? addr_q[1] : 'x;
      chk({tag, "_completed"}, 64'(r_desc | r_fault), 64'd1);
      chk({tag, "_is_fault"}, 64'(r_fault), 64'(ef));
      if (ef) begin
         chk({tag, "_fault_type"}, 64'(r_ft), 64'(eft));
         chk({tag, "_err_code"}, 64'(r_ec), 64'(eec));
         chk({tag, "_mem_reads"}, 64'(addr_q.size()), 64'd0);
         chk({tag, "_desc_kept"}, r_post_desc, last_desc);
      end else begin
         chk({tag, "_descriptor"}, r_d, ed);
         chk({tag, "_mem_reads"}, 64'(addr_q.size()), 64'd2);
         chk({tag, "_addr_low"}, 64'(g0), 64'(ea0));
         chk({tag, "_addr_high"}, 64'(g1), 64'(ea1));
         chk({tag, "_desc_held"}, r_post_desc, ed);
         last_desc = ed;
      end
      chk({tag, "_single_pulse"}, 64'(r_post_pulse), 64'd0);
      chk({tag, "_ready_after"}, 64'(r_post_ready), 64'd1);
      if (elat > 0) chk({tag, "_latency"}, 64'(r_lat), 64'(elat));
   endtask

   // Reference: selector rules evaluated with plain integer arithmetic.
   task automatic model(input logic [15:0] sel, input logic [31:0] base, input logic [15:0] lim,
                        input logic [31:0] lo, input logic [31:0] hi,
                        output bit ef, output logic [1:0] eft, output logic [63:0] ed,
                        output logic [31:0] a0, output logic [31:0] a1);
      int idx;
      idx = int'(sel) / 8;
      ef = 1; eft = 2'd0; ed = 'x;
      a0 = base + 32'(idx * 8);
      a1 = a0 + 32'd4;
      if ((int'(sel) / 4) % 2 == 1) eft = 2'd0;
      else if (idx == 0) eft = 2'd1;
      else if (idx * 8 + 7 > int'(lim)) eft = 2'd2;
      else begin
         ef = 0; ed = {hi, lo};
`ifdef GDT_PRESENT_CHECK_EN
         if (((hi / 32'h8000) % 2) == 0) begin ef = 1; eft = 2'd3; end
`endif
      end
   endtask

   typedef struct {
      logic [15:0] sel; logic [31:0] base; logic [15:0] lim;
      logic [31:0] lo, hi;
      bit fault; logic [1:0] ft; logic [15:0] ec;
      logic [63:0] desc; logic [31:0] a0, a1;
   } vec_t;

   vec_t vecs [12];

   initial begin
      bit          ef, pulse_seen;
      logic [1:0]  eft;
      logic [63:0] ed;
      logic [31:0] a0, a1, lo, hi, base;
      logic [15:0] sel, lim;
      int          w, idx, max_idx;

      vecs[0]  = '{16'h0010, 32'h0000_1000, 16'h00FF, 32'h0000_FFFF, 32'h00CF_9A00, 0, 2'd0, 16'h0000, 64'h00CF9A00_0000FFFF, 32'h0000_1010, 32'h0000_1014};
      vecs[1]  = '{16'h0003, 32'h0000_1000, 16'h00FF, 32'h0, 32'h0, 1, 2'd1, 16'h0000, 64'h0, 32'h0, 32'h0};
      vecs[2]  = '{16'h0018, 32'h0000_1000, 16'h0017, 32'h0, 32'h0, 1, 2'd2, 16'h0018, 64'h0, 32'h0, 32'h0};
      vecs[3]  = '{16'h0010, 32'h0000_2000, 16'h0017, 32'h1234_5678, 32'h0040_9200, 0, 2'd0, 16'h0, 64'h00409200_12345678, 32'h0000_2010, 32'h0000_2014};
      vecs[4]  = '{16'h0008, 32'hFFFF_FFF8, 16'hFFFF, 32'hAAAA_5555, 32'h00CF_9300, 0, 2'd0, 16'h0, 64'h00CF9300_AAAA5555, 32'h0000_0000, 32'h0000_0004};
      vecs[5]  = '{16'h000C, 32'h0000_1000, 16'h00FF, 32'h0, 32'h0, 1, 2'd0, 16'h000C, 64'h0, 32'h0, 32'h0};
      vecs[6]  = '{16'h0007, 32'h0000_1000, 16'h00FF, 32'h0, 32'h0, 1, 2'd0, 16'h0004, 64'h0, 32'h0, 32'h0};
      vecs[7]  = '{16'h001F, 32'h0000_1000, 16'h0017, 32'h0, 32'h0, 1, 2'd0, 16'h001C, 64'h0, 32'h0, 32'h0};
      vecs[8]  = '{16'hFFFB, 32'h0000_0000, 16'hFFFF, 32'h0000_0000, 32'h0000_8000, 0, 2'd0, 16'h0, 64'h00008000_00000000, 32'h0000_FFF8, 32'h0000_FFFC};
      vecs[9]  = '{16'hFFF8, 32'h0000_0000, 16'hFFFE, 32'h0, 32'h0, 1, 2'd2, 16'hFFF8, 64'h0, 32'h0, 32'h0};
      vecs[10] = '{16'h0008, 32'h0000_1000, 16'h0000, 32'h0, 32'h0, 1, 2'd2, 16'h0008, 64'h0, 32'h0, 32'h0};
`ifdef GDT_PRESENT_CHECK_EN
      vecs[11] = '{16'h0010, 32'h0000_1000, 16'h00FF, 32'h0000_FFFF, 32'h00CF_1A00, 1, 2'd3, 16'h0010, 64'h0, 32'h0, 32'h0};
`else
      vecs[11] = '{16'h0010, 32'h0000_1000, 16'h00FF, 32'h0000_FFFF, 32'h00CF_1A00, 0, 2'd0, 16'h0, 64'h00CF1A00_0000FFFF, 32'h0000_1010, 32'h0000_1014};
`endif

      // Reset values.
      repeat (3) @(negedge clock);
      chk("rst_request_ready", 64'(request_ready), 64'd1);
      chk("rst_mem_valid", 64'(memory_request_valid), 64'd0);
      chk("rst_desc_valid", 64'(descriptor_valid), 64'd0);
      chk("rst_fault_valid", 64'(fault_valid), 64'd0);
      chk("rst_descriptor", descriptor, 64'd0);
      chk("rst_fault_type", 64'(fault_type), 64'd0);
      chk("rst_err_code", 64'(fault_error_code), 64'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Directed table at zero wait states.
      foreach (vecs[i]) begin
         mem.delete();
         mem[vecs[i].a0] = vecs[i].lo;
         mem[vecs[i].a1] = vecs[i].hi;
         run_req(vecs[i].sel, vecs[i].base, vecs[i].lim);
         compare($sformatf("vec%0d", i), vecs[i].fault, vecs[i].ft, vecs[i].ec,
                 vecs[i].desc, vecs[i].a0, vecs[i].a1, vecs[i].fault ? 1 : 5);
      end

      // Address channel stalled three cycles on the wrapping entry.
      mem.delete();
      mem[32'h0] = 32'h0BAD_F00D; mem[32'h4] = 32'h00CF_9B00;
      ready_stall = 3;
      run_req(16'h0008, 32'hFFFF_FFF8, 16'h00FF);
      compare("stall", 0, 2'd0, 16'h0, 64'h00CF9B00_0BADF00D, 32'h0, 32'h4, 8);

      // Reset while waiting for the high dword; the late response must be ignored.
      mem.delete();
      fixed_delay = 3;
      addr_q.delete();
      @(negedge clock);
      request_valid = 1; request_selector = 16'h0010; GDTR_base = 32'h1000; GDTR_limit = 16'h00FF;
      @(negedge clock);
      request_valid = 0;
      w = 0;
      while (addr_q.size() < 2 && w < 50) begin @(posedge clock); w++; end
      chk("midrst_reached_high_wait", 64'(addr_q.size()), 64'd2);
      #2 reset = 1'b0;
      @(negedge clock);
      chk("midrst_descriptor_cleared", descriptor, 64'd0);
      @(negedge clock);
      reset = 1'b1;
      pulse_seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (descriptor_valid || fault_valid) pulse_seen = 1;
      end
      chk("midrst_no_pulse", 64'(pulse_seen), 64'd0);
      chk("midrst_ready", 64'(request_ready), 64'd1);
      chk("midrst_reads", 64'(addr_q.size()), 64'd2);
      fixed_delay = -1;
      last_desc = '0;

      // Randomized requests, stalls, response delays and stray responses.
      rand_mode = 1; stray_en = 1;
      for (int t = 0; t < 120; t++) begin
         lim  = 16'($urandom);
         sel  = 16'($urandom);
         base = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         if ($urandom_range(0, 9) < 6) begin
            lim     = 16'($urandom_range(15, 65535));
            max_idx = (int'(lim) - 7) / 8;
            idx     = $urandom_range(1, max_idx);
            sel     = {13'(idx), 1'b0, 2'($urandom)};
         end
         lo = $urandom; hi = $urandom;
         model(sel, base, lim, lo, hi, ef, eft, ed, a0, a1);
         mem.delete();
         mem[a0] = lo; mem[a1] = hi;
         run_req(sel, base, lim);
         compare($sformatf("rnd%0d", t), ef, eft, {sel[15:2], 2'b00}, ed, a0, a1, 0);
      end
      rand_mode = 0; stray_en = 0;

      repeat (4) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
